// File: rtl/axi_tar_lite_slave_if.sv
// AXI4-Lite bus bundle for the four-register slave.
// Signals keep their AXI channel names so the bus reads like the protocol tables.
interface axi_tar_lite_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_tar_lite_slave.sv
// AXI4-Lite slave exposing four 32-bit registers to user logic,
// with independent one-entry AW and W buffers and a one-cycle write strobe per register.
module axi_tar_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  axi_tar_lite_slave_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG3,
  output logic [3:0]                    WR_PULSE
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
    input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]             strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          aw_full;
  logic [1:0]                    aw_idx;
  logic                          w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]             w_strb;
  logic                          bvalid;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [3:0]                    wr_pulse;

  logic                          awready, wready, arready;
  logic                          aw_hs, w_hs, ar_hs, do_write;
  logic [1:0]                    wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;

  // Ready is combinational on reset so the very first cycle out of reset can accept.
  assign awready  = !aw_full && !bvalid && !ARESET;
  assign wready   = !w_full  && !bvalid && !ARESET;
  assign arready  = !rvalid  && !ARESET;
  assign aw_hs    = s_axi.S_AXI_AWVALID && awready;
  assign w_hs     = s_axi.S_AXI_WVALID  && wready;
  assign ar_hs    = s_axi.S_AXI_ARVALID && arready;
  assign do_write = (aw_full || aw_hs) && (w_full || w_hs);

  // Buffered entries take priority over the live bus when completing a write.
  assign wr_idx  = aw_full ? aw_idx : s_axi.S_AXI_AWADDR[3:2];
  assign wr_data = w_full  ? w_data : s_axi.S_AXI_WDATA;
  assign wr_strb = w_full  ? w_strb : s_axi.S_AXI_WSTRB;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (do_write) begin
        regs[wr_idx] <= merge_bytes(regs[wr_idx], wr_data, wr_strb);
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        bvalid       <= 1'b1;
        wr_pulse     <= 4'b0001 << wr_idx;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_idx  <= s_axi.S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= s_axi.S_AXI_WDATA;
          w_strb <= s_axi.S_AXI_WSTRB;
        end
      end
      if (bvalid && s_axi.S_AXI_BREADY) bvalid <= 1'b0;

      // Read samples regs before this edge's write lands, giving pre-write data on collision.
      if (ar_hs) begin
        rdata  <= regs[s_axi.S_AXI_ARADDR[3:2]];
        rvalid <= 1'b1;
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign REG0     = regs[0];
  assign REG1     = regs[1];
  assign REG2     = regs[2];
  assign REG3     = regs[3];
  assign WR_PULSE = wr_pulse;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};
endmodule

// File: tb/tb_axi_tar_lite_slave.sv
// Directed bench for axi_tar_lite_slave: register writes/reads, buffering order,
// byte strobes, response back-pressure, read/write collision and mid-transaction reset.
module tb_axi_tar_lite_slave;
  logic        ACLK;
  logic        ARESET;
  logic [31:0] REG0, REG1, REG2, REG3;
  logic [3:0]  WR_PULSE;
  int          n_tests = 0;
  int          n_fail  = 0;

  axi_tar_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  axi_tar_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .s_axi   (bus.slave),
    .REG0    (REG0),
    .REG1    (REG1),
    .REG2    (REG2),
    .REG3    (REG3),
    .WR_PULSE(WR_PULSE)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic b_ack();
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("bvalid_clr", {31'd0, bus.S_AXI_BVALID}, 32'd0);
  endtask

  // AW and W offered together; each dropped once its own handshake edge passes.
  task automatic write_tx(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] exp_pulse);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_now  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
      tick();
      if (aw_now) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_now)  begin w_done  = 1; bus.S_AXI_WVALID  = 1'b0; end
      n++;
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
    chk("bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
    chk("wr_pulse", {28'd0, WR_PULSE}, {28'd0, exp_pulse});
    b_ack();
    chk("wr_pulse_clr", {28'd0, WR_PULSE}, 32'd0);
  endtask

  task automatic read_tx(input logic [3:0] a, input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
    chk("arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    chk("rdata", bus.S_AXI_RDATA, exp);
    chk("rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
    tick();
    chk("rdata_hold", bus.S_AXI_RDATA, exp);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    chk("rvalid_clr", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    chk("arready_back", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
  endtask

  initial begin
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    chk("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    chk("rst_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
    chk("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    chk("rst_reg0",    REG0, 32'd0);
    chk("rst_pulse",   {28'd0, WR_PULSE}, 32'd0);
    ARESET = 1'b0;
    #1;
    chk("post_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    chk("post_rst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
    chk("post_rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);

    // Basic write then read-back of all four registers
    write_tx(4'h0, 32'h1, 4'hF, 4'b0001);
    write_tx(4'h4, 32'h2, 4'hF, 4'b0010);
    write_tx(4'h8, 32'h3, 4'hF, 4'b0100);
    write_tx(4'hC, 32'h4, 4'hF, 4'b1000);
    chk("reg0", REG0, 32'h1);
    chk("reg1", REG1, 32'h2);
    chk("reg2", REG2, 32'h3);
    chk("reg3", REG3, 32'h4);
    read_tx(4'h0, 32'h1);
    read_tx(4'h4, 32'h2);
    read_tx(4'h8, 32'h3);
    read_tx(4'hC, 32'h4);

    // W three cycles ahead of AW
    bus.S_AXI_WDATA = 32'hAABBCCDD; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("w_first_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    repeat (2) begin
      tick();
      chk("w_first_nobvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
      chk("w_first_reg1_old", REG1, 32'h2);
    end
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
    chk("w_first_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("w_first_reg1", REG1, 32'hAABBCCDD);
    chk("w_first_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("w_first_pulse", {28'd0, WR_PULSE}, 32'h2);
    b_ack();

    // Byte strobes, and all-zero strobe still completing
    write_tx(4'h8, 32'h11223344, 4'hF, 4'b0100);
    write_tx(4'h8, 32'hFFFFFFFF, 4'b0101, 4'b0100);
    chk("strb_reg2", REG2, 32'h11FF33FF);
    write_tx(4'h0, 32'hDEADBEEF, 4'b0000, 4'b0001);
    chk("strb0_reg0", REG0, 32'h1);

    // Response back-pressure: second AW held off until B handshake
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("bp_reg0", REG0, 32'h55);
    repeat (5) begin
      tick();
      chk("bp_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd1);
      chk("bp_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      chk("bp_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("bp_bvalid_clr", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    chk("bp_awready_up", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("bp_aw_taken", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    chk("bp_reg0_hold", REG0, 32'h55);
    bus.S_AXI_WDATA = 32'h66; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("bp_reg0_second", REG0, 32'h66);
    chk("bp_bvalid2", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    b_ack();

    // Read and write to REG3 on the same edge
    write_tx(4'hC, 32'h5, 4'hF, 4'b1000);
    bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'h9; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 4'hC;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("coll_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    chk("coll_rdata",  bus.S_AXI_RDATA, 32'h5);
    chk("coll_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    chk("coll_reg3",   REG3, 32'h9);
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    read_tx(4'hC, 32'h9);

    // Reset with AW buffered and a read response pending
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("pre_rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd1);
    chk("pre_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    ARESET = 1'b1;
    tick();
    chk("mid_rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
    chk("mid_rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    chk("mid_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    chk("mid_rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    chk("mid_rst_regs",    REG0 | REG1 | REG2 | REG3, 32'd0);
    ARESET = 1'b0;
    #1;
    chk("after_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    chk("after_rst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
    bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("after_rst_no_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    chk("after_rst_reg1",      REG1, 32'd0);
    chk("after_rst_pulse",     {28'd0, WR_PULSE}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_tar_lite_slave.md
AXI_TAR_LITE_SLAVE -- requirements
Module: axi_tar_lite_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the data bus and register width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, giving the byte address width; the block decodes 4 registers.
REQ-003 ACLK  input  1  single clock; all logic is on the rising edge.
REQ-004 ARESET  input  1  reset, synchronous and active-high.
REQ-005 S_AXI_AWADDR  input  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT input 3 is ignored.
REQ-006 S_AXI_AWVALID input 1 and S_AXI_AWREADY output 1 form the write-address handshake.
REQ-007 S_AXI_WDATA  input  32  write data; S_AXI_WSTRB  input  4  byte-lane enables.
REQ-008 S_AXI_WVALID input 1 and S_AXI_WREADY output 1 form the write-data handshake.
REQ-009 S_AXI_BRESP output 2, S_AXI_BVALID output 1 and S_AXI_BREADY input 1 form the write-response channel.
REQ-010 S_AXI_ARADDR input C_S_AXI_ADDR_WIDTH, S_AXI_ARVALID input 1 and S_AXI_ARREADY output 1 form the read-address channel; S_AXI_ARPROT input 3 is ignored.
REQ-011 S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1 and S_AXI_RREADY input 1 form the read-data channel.
REQ-012 REG0..REG3  output  32 each  current register contents to user logic.
REQ-013 WR_PULSE  output  4  one-cycle strobe per register written.

Function
REQ-014 Register index SHALL be addr[3:2]; addr[1:0] ignored; all 4 indices valid, so BRESP and RRESP SHALL always be OKAY (2'b00).
REQ-015 The write side SHALL hold a one-entry AW buffer and a one-entry W buffer, filled independently; AW and W may arrive in any order or in the same cycle.
REQ-016 AWREADY SHALL be high iff the AW buffer is empty, BVALID is low and ARESET is low; WREADY follows the same rule using the W buffer.
REQ-017 On the rising edge where address and data are both available (buffered or handshaking in that cycle), the register SHALL be updated per byte lane where WSTRB is 1, the buffers cleared, BVALID set and WR_PULSE[index] set for exactly one cycle.
REQ-018 Write latency: with AW and W handshaking on the same edge, the REGn value and BVALID SHALL be visible in the following cycle.
REQ-019 BVALID SHALL stay high until the edge where BREADY is high; no new AW/W SHALL be accepted while BVALID is high.
REQ-020 WSTRB = 4'b0000 SHALL leave the register unchanged but still produce BVALID; WR_PULSE still pulses.
REQ-021 ARREADY SHALL be high iff RVALID is low and ARESET is low.
REQ-022 On an AR handshake edge, RDATA SHALL capture the addressed register and RVALID SHALL be set; RDATA SHALL hold stable while RVALID is high and RREADY is low.
REQ-023 RVALID SHALL clear on the edge where RREADY is high; ARREADY rises the cycle after.
REQ-024 Read and write to the same register completing on the same edge: RDATA SHALL return the pre-write value.
REQ-025 Read and write channels SHALL operate concurrently without mutual stalling.

Reset
REQ-026 While ARESET is high on a clock edge: REG0..REG3 = 0, WR_PULSE = 0, AWREADY = WREADY = ARREADY = 0, BVALID = RVALID = 0, RDATA = 0, BRESP = RRESP = 0, buffers emptied.
REQ-027 Reset asserted mid-transaction SHALL discard any buffered AW/W and pending B/R responses with no register update.
REQ-028 The first cycle after ARESET deasserts SHALL have AWREADY, WREADY and ARREADY high.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC and read them back -> RDATA 0x1..0x4, all responses OKAY, REG0..REG3 = 1..4.
REQ-030 W 0xAABBCCDD arrives 3 cycles before AW at addr 0x4 -> WREADY drops after the W handshake; REG1 = 0xAABBCCDD one cycle after the AW handshake; BVALID then high.
REQ-031 REG2 = 0x11223344, write 0xFFFFFFFF with WSTRB 4'b0101 -> REG2 = 0x11FF33FF; WR_PULSE = 4'b0100 for one cycle.
REQ-032 BREADY held low 5 cycles after a write -> BVALID held high, AWREADY/WREADY low throughout; a second AW offered is accepted only after the B handshake.
REQ-033 REG3 = 0x5, write 0x9 to 0xC and read 0xC with both completing on the same edge -> RDATA = 0x5; next read returns 0x9.
REQ-034 ARESET pulsed high for 1 cycle with AW buffered and RVALID high -> all outputs per REQ-026, REG0..REG3 = 0, no BVALID afterwards.
